// File: rtl/shared_pkg.sv
// Types and constants shared by the ALSU arbiter and its response pipe.
package shared_pkg;

  localparam string INPUT_PRIORITY = "A";
  localparam string FULL_ADDER     = "ON";

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] A;
    logic [2:0] B;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_A;
    logic       red_op_B;
    logic       bypass_A;
    logic       bypass_B;
  } alsu_cmd_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic id;
    logic invalid;
  } rsp_tag_t;

  localparam int RSP_STAGES = 3;

  // Bypassing a zero A makes the ALSU output 0, which flushes its shift register.
  localparam alsu_cmd_t ALSU_IDLE_CMD = '{
    opcode: 3'd0, A: 3'd0, B: 3'd0, cin: 1'b0, serial_in: 1'b0,
    direction: 1'b0, red_op_A: 1'b0, red_op_B: 1'b0,
    bypass_A: 1'b1, bypass_B: 1'b0
  };

  function automatic logic cmd_invalid(alsu_cmd_t c);
    logic bad;
    bad = (c.opcode inside {3'd6, 3'd7}) ||
          ((c.red_op_A || c.red_op_B) && (c.opcode > 3'd1));
    return bad && !(c.bypass_A || c.bypass_B);
  endfunction

endpackage

// File: rtl/alsu_rsp_pipe.sv
// Tag shift register that follows each command through the ALSU and
// registers the ALSU result alongside the matching tag.
module alsu_rsp_pipe
  import shared_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_valid,
  input  logic       push_id,
  input  logic       push_invalid,
  input  logic [5:0] alsu_out,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [5:0] rsp_out,
  output logic       rsp_invalid
);

  rsp_tag_t tag_reg [RSP_STAGES];
  rsp_tag_t push_tag;
  rsp_tag_t tail_tag;

  assign push_tag = '{valid: push_valid, id: push_id, invalid: push_invalid};
  assign tail_tag = tag_reg[RSP_STAGES-1];

  for (genvar gi = 0; gi < RSP_STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst) tag_reg[gi] <= '0;
        else      tag_reg[gi] <= push_tag;
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst) tag_reg[gi] <= '0;
        else      tag_reg[gi] <= tag_reg[gi-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_out     <= 6'd0;
      rsp_invalid <= 1'b0;
    end else begin
      rsp_valid   <= tail_tag.valid;
      rsp_id      <= tail_tag.id;
      rsp_out     <= alsu_out;
      rsp_invalid <= tail_tag.valid & tail_tag.invalid;
    end
  end

endmodule

// File: rtl/alsu_arbiter.sv
// Round-robin arbiter sharing one ALSU between two requesters, with a lock
// that lets one owner chain shift/rotate commands back-to-back.
module alsu_arbiter
  import shared_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_lock,
  input  logic [15:0] req_cmd0,
  input  logic [15:0] req_cmd1,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [5:0]  rsp_out,
  output logic        rsp_invalid,
  output logic        alsu_rst,
  output logic [2:0]  alsu_opcode,
  output logic [2:0]  alsu_A,
  output logic [2:0]  alsu_B,
  output logic        alsu_cin,
  output logic        alsu_serial_in,
  output logic        alsu_direction,
  output logic        alsu_red_op_A,
  output logic        alsu_red_op_B,
  output logic        alsu_bypass_A,
  output logic        alsu_bypass_B,
  input  logic [5:0]  alsu_out,
  input  logic [15:0] alsu_leds
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e       state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_reg, last_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  alsu_cmd_t        cmd_reg, cmd_next;
  logic             alsu_rst_reg;

  logic [1:0] grant;
  logic       gid;
  logic       accept;
  logic       sel_lock;
  alsu_cmd_t  sel_cmd;
  logic       sel_invalid;

  // The LED bus is observed by the system but carries nothing the arbiter needs.
  logic unused_leds;
  assign unused_leds = ^alsu_leds;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    grant      = 2'b00;

    case (state_reg)
      ARB: begin
        if (req_valid == 2'b11) grant = last_reg ? 2'b01 : 2'b10;
        else                    grant = req_valid;
      end
      LOCKED:  grant = req_valid & (owner_reg ? 2'b10 : 2'b01);
      default: grant = 2'b00;
    endcase

    gid      = grant[1];
    accept   = |grant;
    sel_cmd  = gid ? req_cmd1 : req_cmd0;
    sel_lock = req_lock[gid];

    if (accept) begin
      last_next = gid;
      if (state_reg == ARB) begin
        if (sel_lock) begin
          state_next = LOCKED;
          owner_next = gid;
          cnt_next   = CNT_W'(1);
        end
      end else if (!sel_lock || cnt_reg == CNT_W'(LOCK_MAX - 1)) begin
        // Lock released voluntarily or forced once the owner hits LOCK_MAX.
        state_next = ARB;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    cmd_next    = accept ? sel_cmd : ALSU_IDLE_CMD;
    sel_invalid = cmd_invalid(sel_cmd);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ARB;
      owner_reg    <= 1'b0;
      last_reg     <= 1'b1;
      cnt_reg      <= '0;
      cmd_reg      <= ALSU_IDLE_CMD;
      alsu_rst_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      cmd_reg      <= cmd_next;
      alsu_rst_reg <= 1'b0;
    end
  end

  assign req_ready      = grant;
  assign alsu_rst       = alsu_rst_reg;
  assign alsu_opcode    = cmd_reg.opcode;
  assign alsu_A         = cmd_reg.A;
  assign alsu_B         = cmd_reg.B;
  assign alsu_cin       = cmd_reg.cin;
  assign alsu_serial_in = cmd_reg.serial_in;
  assign alsu_direction = cmd_reg.direction;
  assign alsu_red_op_A  = cmd_reg.red_op_A;
  assign alsu_red_op_B  = cmd_reg.red_op_B;
  assign alsu_bypass_A  = cmd_reg.bypass_A;
  assign alsu_bypass_B  = cmd_reg.bypass_B;

  alsu_rsp_pipe u_rsp_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (accept),
    .push_id      (gid),
    .push_invalid (sel_invalid),
    .alsu_out     (alsu_out),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_out      (rsp_out),
    .rsp_invalid  (rsp_invalid)
  );

endmodule
